// File: rtl/pif_led_breather.sv
// Multi-channel LED driver: a tick divider steps a shared ramp, and each channel
// shows it as off, on, blink or PWM breathing, with a quarter-ramp phase offset.
module pif_led_breather #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned B        = 5,
  parameter int unsigned DIV_W    = 32
) (
  input  logic                  Clk,
  input  logic                  sys_rst,
  input  logic                  en,
  input  logic [DIV_W-1:0]      div_val,
  input  logic [2*CHANNELS-1:0] mode,
  output logic [CHANNELS-1:0]   led_n,
  output logic                  tick,
  output logic [B+1:0]          level
);

  localparam int unsigned CW = DIV_W + 1;
  localparam int unsigned LW = B + 2;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  logic [CW-1:0]       div_cnt;
  logic [B-1:0]        pwm_cnt;
  logic [CHANNELS-1:0] on_c;

  // The divider MSB is the tick: it sets when the count underflows past zero.
  assign tick = div_cnt[CW-1];

  always_ff @(posedge Clk or negedge sys_rst) begin
    if (!sys_rst) begin
      div_cnt <= '0;
    end else if (!en || tick) begin
      div_cnt <= {1'b0, div_val};
    end else begin
      div_cnt <= div_cnt - CW'(1);
    end
  end

  // Shared ramp advances once per tick and wraps naturally.
  always_ff @(posedge Clk or negedge sys_rst) begin
    if (!sys_rst) begin
      level <= '0;
    end else if (en && tick) begin
      level <= level + LW'(1);
    end
  end

  always_ff @(posedge Clk or negedge sys_rst) begin
    if (!sys_rst) begin
      pwm_cnt <= '0;
    end else if (en) begin
      pwm_cnt <= pwm_cnt + B'(1);
    end
  end

  // Odd phases count the duty back down, turning the sawtooth into a triangle.
  function automatic logic chan_on(input logic [1:0]    md,
                                   input logic [LW-1:0] lv,
                                   input logic [B-1:0]  pc);
    logic [1:0]   ph;
    logic [B-1:0] duty;
    logic         on;
    ph   = lv[LW-1:B];
    duty = ph[0] ? ~lv[B-1:0] : lv[B-1:0];
    on   = 1'b0;
    case (md)
      MODE_OFF:     on = 1'b0;
      MODE_ON:      on = 1'b1;
      MODE_BLINK:   on = ~ph[0];
      MODE_BREATHE: on = (pc < duty);
      default:      on = 1'b0;
    endcase
    return on;
  endfunction

  always_comb begin
    on_c = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      on_c[i] = chan_on(mode[2*i +: 2], level + (LW'(i) << B), pwm_cnt);
    end
  end

  always_ff @(posedge Clk or negedge sys_rst) begin
    if (!sys_rst) begin
      led_n <= '1;
    end else if (!en) begin
      led_n <= '1;
    end else begin
      led_n <= ~on_c;
    end
  end

endmodule

// File: tb/tb_pif_led_breather.sv
// Scoreboard bench for pif_led_breather: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_pif_led_breather;

  localparam int unsigned CH = 2;
  localparam int unsigned BW = 3;
  localparam int unsigned DW = 8;

  logic            Clk = 1'b0;
  logic            sys_rst;
  logic            en;
  logic [DW-1:0]   div_val;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   led_n;
  logic            tick;
  logic [BW+1:0]   level;

  pif_led_breather #(.CHANNELS(CH), .B(BW), .DIV_W(DW)) dut (
    .Clk(Clk), .sys_rst(sys_rst), .en(en), .div_val(div_val),
    .mode(mode), .led_n(led_n), .tick(tick), .level(level)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct packed {
    int         at;
    logic [2:0] msk;
    logic [1:0] led;
    logic       tk;
    logic [4:0] lvl;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    checks = 0;
  int    errors = 0;

  // Hand-derived expectations (CHANNELS=2, B=3)
  localparam logic       TK1 [9]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1};
  localparam logic [4:0] LV1 [9]  = '{5'd0,5'd1,5'd1,5'd1,5'd1,5'd2,5'd2,5'd2,5'd2};
  localparam logic       TK2 [12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [4:0] LV2 [12] = '{5'd3,5'd3,5'd3,5'd3,5'd4,5'd4,5'd4,5'd4,5'd4,5'd4,5'd4,5'd5};
  localparam logic       TK5 [7]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0};
  localparam logic [4:0] LV5 [7]  = '{5'd0,5'd1,5'd1,5'd2,5'd2,5'd3,5'd3};
  localparam logic [1:0] LD6 [16] = '{2'b11,2'b10,2'b10,2'b10,2'b11,2'b11,2'b11,2'b11,
                                      2'b11,2'b10,2'b10,2'b10,2'b11,2'b11,2'b11,2'b11};
  localparam logic [1:0] LD7 [18] = '{2'b11,2'b01,2'b01,2'b01,2'b01,2'b11,2'b11,2'b11,2'b11,
                                      2'b01,2'b01,2'b01,2'b01,2'b11,2'b11,2'b11,2'b11,2'b01};
  localparam logic [1:0] LD9 [5]  = '{2'b01,2'b01,2'b01,2'b11,2'b11};
  localparam logic       TK9 [5]  = '{1'b0,1'b0,1'b1,1'b0,1'b1};
  localparam logic [4:0] LV9 [5]  = '{5'd3,5'd3,5'd3,5'd4,5'd4};
  localparam logic [1:0] LD10 [9] = '{2'b10,2'b10,2'b10,2'b10,2'b10,2'b10,2'b10,2'b01,2'b01};
  localparam logic       TK10 [9] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0};
  localparam logic [4:0] LV10 [9] = '{5'd5,5'd5,5'd6,5'd6,5'd7,5'd7,5'd8,5'd8,5'd9};
  localparam logic [1:0] LD11 [7] = '{2'b01,2'b01,2'b01,2'b01,2'b01,2'b10,2'b10};
  localparam logic       TK11 [7] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0};
  localparam logic [4:0] LV11 [7] = '{5'd30,5'd30,5'd31,5'd31,5'd0,5'd0,5'd1};

  // msk bit2 = led_n, bit1 = tick, bit0 = level
  task automatic push(input int at, input string nm, input logic [2:0] msk,
                      input logic [1:0] led, input logic tk, input logic [4:0] lvl);
    exp_t e;
    e.at = at; e.msk = msk; e.led = led; e.tk = tk; e.lvl = lvl;
    sb_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Monitor: compare every expectation due at this cycle
  initial begin
    exp_t  e;
    string nm;
    bit    ok;
    forever begin
      @(negedge Clk);
      while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
        e  = sb_q.pop_front();
        nm = nm_q.pop_front();
        checks++;
        ok = (e.at == cyc);
        if (e.msk[2] && led_n !== e.led) ok = 1'b0;
        if (e.msk[1] && tick  !== e.tk)  ok = 1'b0;
        if (e.msk[0] && level !== e.lvl) ok = 1'b0;
        if (!ok) begin
          errors++;
          $display("FAIL %s cyc=%0d (due %0d): got led_n=%b tick=%b level=%0d, want led_n=%b tick=%b level=%0d (mask %b)",
                   nm, cyc, e.at, led_n, tick, level, e.led, e.tk, e.lvl, e.msk);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b0; en = 1'b0; div_val = 8'd2; mode = 4'b0000;
    goto(2);
    push(2, "reset_state", 3'b111, 2'b11, 1'b0, 5'd0);
    sys_rst = 1'b1; en = 1'b1;
    for (int k = 0; k < 9; k++) push(3 + k, "first_tick_period4", 3'b111, 2'b11, TK1[k], LV1[k]);

    goto(12);
    div_val = 8'd5;
    for (int k = 0; k < 12; k++) push(12 + k, "div_change_reload", 3'b111, 2'b11, TK2[k], LV2[k]);

    goto(24);
    push(24, "mode_latency_pre", 3'b111, 2'b11, 1'b0, 5'd5);
    mode = 4'b0100;
    push(25, "mode_ch1_on", 3'b100, 2'b01, 1'b0, 5'd0);
    goto(25);
    mode = 4'b0000;
    push(26, "mode_all_off", 3'b101, 2'b11, 1'b0, 5'd5);
    goto(26);
    mode = 4'b0101;
    push(27, "mode_both_on", 3'b111, 2'b00, 1'b0, 5'd5);

    goto(28);
    sys_rst = 1'b0; mode = 4'b0000; div_val = 8'd0;
    push(28, "async_reset", 3'b111, 2'b11, 1'b0, 5'd0);
    push(29, "reset_held", 3'b111, 2'b11, 1'b0, 5'd0);
    goto(29);
    sys_rst = 1'b1;
    for (int k = 0; k < 7; k++) push(30 + k, "release_ramp", 3'b111, 2'b11, TK5[k], LV5[k]);
    goto(34);
    div_val = 8'd255;

    goto(36);
    mode = 4'b0011;
    for (int k = 0; k < 16; k++) push(37 + k, "breathe_duty3", 3'b101, LD6[k], 1'b0, 5'd3);
    goto(52);
    mode = 4'b1100;
    for (int k = 0; k < 18; k++) push(53 + k, "breathe_ch1_duty4", 3'b101, LD7[k], 1'b0, 5'd3);

    goto(70);
    en = 1'b0; div_val = 8'd2;
    for (int k = 0; k < 20; k++) push(71 + k, "enable_low_hold", 3'b111, 2'b11, 1'b0, 5'd3);
    goto(90);
    en = 1'b1;
    for (int k = 0; k < 5; k++) push(91 + k, "enable_rise", 3'b111, LD9[k], TK9[k], LV9[k]);
    goto(93);
    div_val = 8'd0;

    goto(95);
    mode = 4'b1010;
    for (int k = 0; k < 9; k++) push(96 + k, "blink_quarter", 3'b111, LD10[k], TK10[k], LV10[k]);
    for (int k = 0; k < 7; k++) push(146 + k, "level_wrap", 3'b111, LD11[k], TK11[k], LV11[k]);

    goto(153);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
